// File: rtl/lms_err_monitor.sv
// lms_err_monitor: tracks the mean squared error of an LMS adaptive filter.
// Each window covers 2^WIN_LOG2 valid error samples. The monitor reports the
// mean for each window and classifies the filter as ADAPT, CONVERGED or
// DIVERGED.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   e_in, e_valid  signed error sample and its qualifier
//   clear          synchronous restart of all monitoring state
//   mse_out        mean squared scaled error of the last completed window
//   mse_valid      one-cycle pulse when mse_out updates
//   state          00 ADAPT, 01 CONVERGED, 10 DIVERGED
//   sat_flag       sticky; set when a scaled sample had to be saturated
//
// Pipeline: input register -> scale/saturate/square register ->
// accumulate and window output -> state update.
module lms_err_monitor #(
  parameter int unsigned W2       = 35,
  parameter int unsigned E_SHIFT  = 7,
  parameter int unsigned WIN_LOG2 = 8,
  parameter logic [31:0] TH_CONV  = 32'd1024,
  parameter logic [31:0] TH_EXIT  = 32'd4096,
  parameter logic [31:0] TH_DIV   = 32'd1048576,
  parameter int unsigned HOLD     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [W2-1:0] e_in,
  input  logic                 e_valid,
  input  logic                 clear,
  output logic [31:0]          mse_out,
  output logic                 mse_valid,
  output logic [1:0]           state,
  output logic                 sat_flag
);

  localparam int unsigned AW = 32 + WIN_LOG2;
  localparam int unsigned HW = (HOLD < 2) ? 1 : $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    ST_ADAPT = 2'b00,
    ST_CONV  = 2'b01,
    ST_DIV   = 2'b10
  } state_t;

  logic signed [W2-1:0] e_q;
  logic                 v0_q;
  logic                 v1_q;
  logic [31:0]          sq_q;
  logic [AW-1:0]        acc_q;
  logic [WIN_LOG2-1:0]  cnt_q;
  logic [HW-1:0]        hold_q;
  state_t               state_q;

  // Input capture register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q  <= '0;
      v0_q <= 1'b0;
    end else if (clear) begin
      e_q  <= '0;
      v0_q <= 1'b0;
    end else begin
      v0_q <= e_valid;
      if (e_valid) e_q <= e_in;
    end
  end

  // Scale, saturate to 16-bit signed and square
  logic signed [W2-1:0]  es_full;
  logic [W2-16:0]        es_hi;
  logic                  es_sat;
  logic signed [15:0]    es16;
  logic signed [31:0]    prod;

  always_comb begin
    es_full = e_q >>> E_SHIFT;
    // Scaled value fits in 16 bits only when bits [W2-1:15] are all sign copies
    es_hi   = es_full[W2-1:15];
    es_sat  = ~((&es_hi) | ~(|es_hi));
    es16    = es_full[15:0];
    if (es_sat) es16 = es_full[W2-1] ? 16'sh8000 : 16'sh7fff;
    prod    = 32'(es16) * 32'(es16);
  end

  // Squared sample register and sticky saturation flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      sq_q     <= '0;
      sat_flag <= 1'b0;
    end else if (clear) begin
      v1_q     <= 1'b0;
      sq_q     <= '0;
      sat_flag <= 1'b0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) sq_q <= 32'(prod);
      if (v0_q && es_sat) sat_flag <= 1'b1;
    end
  end

  // Window accumulation; the closing sample goes straight into the mean so
  // the next window starts from zero without losing a sample
  logic [AW-1:0] sum;
  assign sum = acc_q + AW'(sq_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      mse_out   <= '0;
      mse_valid <= 1'b0;
    end else if (clear) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      mse_out   <= '0;
      mse_valid <= 1'b0;
    end else begin
      mse_valid <= 1'b0;
      if (v1_q) begin
        cnt_q <= cnt_q + WIN_LOG2'(1);
        if (cnt_q == '1) begin
          mse_out   <= 32'(sum >> WIN_LOG2);
          mse_valid <= 1'b1;
          acc_q     <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

  // Convergence classifier, evaluated once per completed window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ADAPT;
      hold_q  <= '0;
    end else if (clear) begin
      state_q <= ST_ADAPT;
      hold_q  <= '0;
    end else if (mse_valid) begin
      if (mse_out >= TH_DIV) begin
        state_q <= ST_DIV;
        hold_q  <= '0;
      end else begin
        case (state_q)
          ST_ADAPT: begin
            if (mse_out < TH_CONV) begin
              if (hold_q + HW'(1) == HW'(HOLD)) begin
                state_q <= ST_CONV;
                hold_q  <= '0;
              end else begin
                hold_q <= hold_q + HW'(1);
              end
            end else begin
              hold_q <= '0;
            end
          end
          ST_CONV: begin
            if (mse_out >= TH_EXIT) begin
              state_q <= ST_ADAPT;
              hold_q  <= '0;
            end
          end
          ST_DIV:  state_q <= ST_DIV;
          default: begin
            state_q <= ST_ADAPT;
            hold_q  <= '0;
          end
        endcase
      end
    end
  end

  assign state = state_q;

endmodule
